// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared mode encodings, default geometry and pointer sizing.
package mem_arbiter_pkg;
  localparam int MODE_RR = 0;
  localparam int MODE_FIXED = 1;
  localparam int DEF_CH = 2;
  localparam int DEF_AW = 20;
  localparam int DEF_DW = 8;
  function automatic int ptr_w(input int ch);
    return ch > 1 ? $clog2(ch) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: one-hot grant of the first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int CH = 2,
  parameter int PW = 1
) (
  input  logic [CH-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [CH-1:0] grant
);
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (!found && req[(int'(ptr) + i) % CH]) begin
        grant[(int'(ptr) + i) % CH] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port among CH channels,
// issuing combinationally and acknowledging one cycle later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int CH = DEF_CH,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int MODE = MODE_RR,
  parameter logic [CH*AW-1:0] BASE = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [CH-1:0]   req,
  input  logic [CH-1:0]   we,
  input  logic [CH*AW-1:0] address,
  input  logic [CH*DW-1:0] out,
  output logic [CH-1:0]   ack,
  output logic [DW-1:0]   in_data,
  output logic [AW-1:0]   mem_a,
  output logic [DW-1:0]   mem_o,
  output logic            mem_w,
  input  logic [DW-1:0]   mem_i
);
  localparam int PW = ptr_w(CH);
  logic [CH-1:0] pick, grant;
  logic [PW-1:0] ptr, ptr_in, nxt_ptr;
  logic [AW-1:0] last_a, sel_a;
  logic [DW-1:0] sel_o;
  logic sel_w;
  assign ptr_in = (MODE == MODE_FIXED) ? '0 : ptr;
  // Channels in their ack cycle sit out, so a held req is never reissued.
  rr_pick #(.CH(CH), .PW(PW)) u_pick (
    .req(req & ~ack),
    .ptr(ptr_in),
    .grant(pick)
  );
  assign grant = reset_n ? pick : '0;
  always_comb begin
    sel_a = last_a;
    sel_o = '0;
    sel_w = 1'b0;
    nxt_ptr = ptr;
    for (int k = 0; k < CH; k++) begin
      if (grant[k]) begin
        sel_a = address[k*AW +: AW] + BASE[k*AW +: AW];
        sel_o = out[k*DW +: DW];
        sel_w = we[k];
        nxt_ptr = PW'((k + 1) % CH);
      end
    end
  end
  assign mem_a = reset_n ? sel_a : '0;
  assign mem_o = sel_o;
  assign mem_w = sel_w;
  assign in_data = |ack ? mem_i : '0;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ack <= '0;
      ptr <= '0;
      last_a <= '0;
    end else begin
      ack <= grant;
      if (|grant) begin
        last_a <= sel_a;
        ptr <= nxt_ptr;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of a round-robin and a fixed-priority
// arbiter sharing one stimulus, each with its own memory model.
module tb_mem_arbiter;
  localparam logic [39:0] BASE = {20'hA0000, 20'hFFFF0};
  logic clock = 1'b0;
  logic reset_n;
  logic [1:0] req, we;
  logic [19:0] a0, a1;
  logic [7:0] o0, o1;
  logic [1:0] ack, ack1;
  logic [7:0] in_data, in_data1, mem_o, mem_o1, mem_i, mem_i1;
  logic [19:0] mem_a, mem_a1;
  logic mem_w, mem_w1;
  logic [7:0] mem [logic [19:0]];
  int n = 0;
  int errs = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.CH(2), .AW(20), .DW(8), .MODE(0), .BASE(BASE)) u0 (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we),
    .address({a1, a0}), .out({o1, o0}), .ack(ack), .in_data(in_data),
    .mem_a(mem_a), .mem_o(mem_o), .mem_w(mem_w), .mem_i(mem_i)
  );
  mem_arbiter #(.CH(2), .AW(20), .DW(8), .MODE(1), .BASE(BASE)) u1 (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we),
    .address({a1, a0}), .out({o1, o0}), .ack(ack1), .in_data(in_data1),
    .mem_a(mem_a1), .mem_o(mem_o1), .mem_w(mem_w1), .mem_i(mem_i1)
  );

  function automatic logic [7:0] rd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h3C);
  endfunction

  // Read-before-write synchronous memory.
  always @(posedge clock) begin
    mem_i <= rd(mem_a);
    if (mem_w) mem[mem_a] = mem_o;
    mem_i1 <= ~mem_a1[7:0];
  end

  task automatic test_reset;
    reset_n = 1'b0; req = 2'b11; we = 2'b11; a0 = 20'h00020; a1 = 20'h00003; o0 = 8'hAA; o1 = 8'h55;
    repeat (2) @(negedge clock);
    #1;
    n++; if (ack !== 2'b00) begin errs++; $display("FAIL reset_ack got %b exp 00", ack); end
    n++; if (ack1 !== 2'b00) begin errs++; $display("FAIL reset_ack1 got %b exp 00", ack1); end
    n++; if (mem_w !== 1'b0) begin errs++; $display("FAIL reset_mem_w got %b exp 0", mem_w); end
    n++; if (mem_a !== 20'h0) begin errs++; $display("FAIL reset_mem_a got %h exp 00000", mem_a); end
    n++; if (mem_o !== 8'h0) begin errs++; $display("FAIL reset_mem_o got %h exp 00", mem_o); end
    n++; if (in_data !== 8'h0) begin errs++; $display("FAIL reset_in_data got %h exp 00", in_data); end
  endtask

  task automatic test_read_base;
    @(negedge clock); reset_n = 1'b1; req = 2'b10; we = 2'b00; #1;
    n++; if (mem_a !== 20'hA0003) begin errs++; $display("FAIL base_mem_a got %h exp a0003", mem_a); end
    n++; if (mem_w !== 1'b0) begin errs++; $display("FAIL base_mem_w got %b exp 0", mem_w); end
    @(negedge clock); #1;
    n++; if (ack !== 2'b10) begin errs++; $display("FAIL base_ack got %b exp 10", ack); end
    n++; if (in_data !== 8'h77) begin errs++; $display("FAIL base_in_data got %h exp 77", in_data); end
    n++; if (mem_a !== 20'hA0003) begin errs++; $display("FAIL base_hold_a got %h exp a0003", mem_a); end
    @(negedge clock); req = 2'b00; #1;
    n++; if (ack !== 2'b00) begin errs++; $display("FAIL base_no_reissue got %b exp 00", ack); end
  endtask

  task automatic test_wrap_rw;
    @(negedge clock); req = 2'b01; we = 2'b01; #1;
    n++; if (mem_a !== 20'h00010) begin errs++; $display("FAIL wrap_mem_a got %h exp 00010", mem_a); end
    n++; if (mem_w !== 1'b1) begin errs++; $display("FAIL wr_mem_w got %b exp 1", mem_w); end
    n++; if (mem_o !== 8'hAA) begin errs++; $display("FAIL wr_mem_o got %h exp aa", mem_o); end
    @(negedge clock); we = 2'b00; #1;
    n++; if (ack !== 2'b01) begin errs++; $display("FAIL wr_ack got %b exp 01", ack); end
    n++; if (in_data !== 8'h03) begin errs++; $display("FAIL wr_old_data got %h exp 03", in_data); end
    n++; if (mem_w !== 1'b0) begin errs++; $display("FAIL wr_ackcyc_mem_w got %b exp 0", mem_w); end
    @(negedge clock); #1;
    n++; if (mem_a !== 20'h00010 || mem_w !== 1'b0) begin errs++; $display("FAIL rd_issue got %h/%b exp 00010/0", mem_a, mem_w); end
    @(negedge clock); req = 2'b00; #1;
    n++; if (ack !== 2'b01) begin errs++; $display("FAIL rd_ack got %b exp 01", ack); end
    n++; if (in_data !== 8'hAA) begin errs++; $display("FAIL rd_new_data got %h exp aa", in_data); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    logic [1:0] g, g1, pg, pg1;
    a1 = 20'h00005; pg = 2'b00; pg1 = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); req = 2'b11; #1;
      g = (i % 2 == 0) ? 2'b10 : 2'b01;
      g1 = (i % 2 == 0) ? 2'b01 : 2'b10;
      n++; if (mem_a !== ((g == 2'b10) ? 20'hA0005 : 20'h00010)) begin errs++; $display("FAIL rr_mem_a[%0d] got %h grant %b", i, mem_a, g); end
      n++; if (ack !== pg) begin errs++; $display("FAIL rr_ack[%0d] got %b exp %b", i, ack, pg); end
      n++; if (ack1 !== pg1) begin errs++; $display("FAIL fixed_ack[%0d] got %b exp %b", i, ack1, pg1); end
      if (i > 0) begin
        n++; if (in_data !== ((pg == 2'b10) ? 8'h39 : 8'hAA)) begin errs++; $display("FAIL rr_in_data[%0d] got %h", i, in_data); end
      end
      pg = g; pg1 = g1;
    end
    @(negedge clock); req = 2'b00; #1;
    n++; if (ack !== 2'b01) begin errs++; $display("FAIL drop_ack got %b exp 01", ack); end
    n++; if (ack1 !== 2'b10) begin errs++; $display("FAIL drop_ack1 got %b exp 10", ack1); end
  endtask

  task automatic test_reset_in_issue;
    @(negedge clock); reset_n = 1'b0; req = 2'b01; we = 2'b01; o0 = 8'h55; #1;
    n++; if (mem_w !== 1'b0) begin errs++; $display("FAIL rst_issue_mem_w got %b exp 0", mem_w); end
    n++; if (mem_a !== 20'h0) begin errs++; $display("FAIL rst_issue_mem_a got %h exp 00000", mem_a); end
    @(negedge clock); reset_n = 1'b1; req = 2'b00; we = 2'b00; #1;
    n++; if (ack !== 2'b00 || ack1 !== 2'b00) begin errs++; $display("FAIL rst_no_ack got %b/%b exp 00/00", ack, ack1); end
    n++; if (mem_a !== 20'h0) begin errs++; $display("FAIL rst_last_a got %h exp 00000", mem_a); end
    @(negedge clock); req = 2'b11; #1;
    n++; if (mem_a !== 20'h00010) begin errs++; $display("FAIL rst_ptr_zero got %h exp 00010", mem_a); end
    @(negedge clock); req = 2'b00; #1;
    n++; if (ack !== 2'b01) begin errs++; $display("FAIL rst_read_ack got %b exp 01", ack); end
    n++; if (in_data !== 8'hAA) begin errs++; $display("FAIL rst_mem_intact got %h exp aa", in_data); end
    n++; if (mem_a !== 20'h00010 || mem_w !== 1'b0) begin errs++; $display("FAIL idle_hold got %h/%b exp 00010/0", mem_a, mem_w); end
    @(negedge clock); #1;
    n++; if (ack !== 2'b00) begin errs++; $display("FAIL discard_ack got %b exp 00", ack); end
  endtask

  initial begin
    mem[20'hA0003] = 8'h77;
    mem[20'h00010] = 8'h03;
    test_reset();
    test_read_base();
    test_wrap_rw();
    test_back_to_back();
    test_reset_in_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CH, default 2: number of requesting channels (1..8).
REQ-002 Parameter AW, default 20: address width.
REQ-003 Parameter DW, default 8: data width.
REQ-004 Parameter MODE, default 0: 0 = round-robin, 1 = fixed priority (channel 0 highest).
REQ-005 Parameter BASE, default all-zero, CH*AW bits: per-channel address offset, channel k in bits [k*AW +: AW].
REQ-006 clock  in  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-008 req  in  CH  per-channel access request, held high until ack.
REQ-009 we  in  CH  per-channel write enable, qualified by req.
REQ-010 address  in  CH*AW  per-channel address, channel k in [k*AW +: AW].
REQ-011 out  in  CH*DW  per-channel write data.
REQ-012 ack  out  CH  one-cycle completion pulse per channel.
REQ-013 in_data  out  DW  read data, shared, valid while any ack bit is high.
REQ-014 mem_a  out  AW  address to synchronous block memory.
REQ-015 mem_o  out  DW  write data to memory.
REQ-016 mem_w  out  1  memory write strobe.
REQ-017 mem_i  in  DW  memory read data, registered in memory, valid one cycle after mem_a.

Function
REQ-018 Each cycle the arbiter SHALL select at most one channel k with req[k]=1 that is not already in its ack cycle.
REQ-019 Issue cycle: mem_a = address[k] + BASE[k] modulo 2^AW (carry discarded); mem_o = out[k]; mem_w = we[k].
REQ-020 No grant: mem_w SHALL be 0 and mem_a SHALL hold its last value.
REQ-021 ack[k] SHALL be 1 exactly in the cycle after issue; in_data SHALL equal mem_i in that cycle.
REQ-022 Write completion: in_data SHALL carry the pre-write memory content (read-before-write); writers ignore it.
REQ-023 A channel in its ack cycle SHALL be excluded from arbitration, so a held req is never issued twice.
REQ-024 Throughput: one issue per cycle when two or more channels alternate; a single channel gets one issue every 2 cycles.
REQ-025 MODE=0: pointer SHALL advance to (granted+1) mod CH after each grant; search starts at pointer, increasing index with wrap-around.
REQ-026 MODE=1: lowest-index eligible channel SHALL win; pointer unused.
REQ-027 Simultaneous requests from all channels, MODE=0: each channel SHALL be served within CH cycles.
REQ-028 req dropped before ack: access already issued SHALL still complete and ack; a request never issued SHALL be discarded.
REQ-029 At most one ack bit SHALL be high in any cycle.

Reset
REQ-030 While reset_n=0: ack=0, mem_w=0, mem_a=0, mem_o=0, in_data=0, pointer=0, pending=none.
REQ-031 Reset asserted in an issue cycle SHALL suppress the following ack; no write SHALL reach memory in any cycle with reset_n=0.
REQ-032 First grant possible in the first cycle after reset_n rises.

Structure
REQ-033 Shared package SHALL hold MODE encodings (RR, FIXED) and the default BASE layout helper constants.
REQ-034 One sub-module, rr_pick (CH-wide request vector + pointer -> one-hot grant), SHALL be instantiated; everything else lives in mem_arbiter.
REQ-035 Estimated size 150-250 RTL lines; no memory inside the block.

Verification
REQ-036 CH=2, BASE1=0xA0000: ch1 reads 0x00003 -> mem_a=0xA0003 at issue, ack[1] next cycle, in_data = mem[0xA0003].
REQ-037 MODE=0, both req held 8 cycles -> grants 0,1,0,1,... ; ack alternates every cycle; no double issue.
REQ-038 MODE=1, both req held -> ch0 granted every other cycle, ch1 granted only in ch0's ack cycles.
REQ-039 ch0 writes 0xAA to 0x00010 then reads it -> first ack in_data=0x03 (old), second ack in_data=0xAA.
REQ-040 BASE=0xFFFF0, address 0x00020 -> mem_a=0x00010 (wrap).
REQ-041 reset_n low in issue cycle of a write -> no ack, mem_w=0 during reset, memory unchanged, pointer=0 after release.
